// File: rtl/wb_sram_responder_if.sv
// Wishbone classic bus bundle between a bus master and wb_sram_responder.
interface wb_sram_responder_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_sram_responder.sv
// Wishbone classic slave backed by a word-wide on-chip SRAM. Each request is
// latched, optionally held for WAIT_STATES cycles, and ended by exactly one
// ack (address inside the window) or err (outside) pulse. An idle gap cycle
// always follows a termination.
module wb_sram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_sram_responder_if.slave wb
);
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TERM} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_dat;
  logic [3:0]            r_sel;
  logic                  r_we;
  logic                  r_hit;
  logic [31:0]           r_dat_o;
  logic                  r_ack;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];

  logic [31:0]           w_off;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_finish;
  logic                  w_write;

  // Offset from the window base; the unsigned wrap makes addresses below the
  // base land far outside the span, so one compare covers both ends.
  assign w_off   = wb.wb_adr_i - BASE_ADDR;
  assign w_hit   = {1'b0, w_off} < SPAN_BYTES;
  assign w_write = w_finish && r_hit && r_we;

  assign wb.wb_dat_o = r_dat_o;
  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;

  // Next-state and control strobes: accept a request, or complete the latched one.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // The ack/err cycle is not a sampling cycle: this forces the idle gap.
        if (wb.wb_cyc_i && wb.wb_stb_i && !r_ack && !r_err) begin
          w_accept = 1'b1;
          w_next   = (WAIT_STATES == 0) ? ST_TERM : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!wb.wb_cyc_i)      w_next = ST_IDLE;
        else if (r_cnt == 4'd1) w_next = ST_TERM;
      end
      ST_TERM: begin
        w_next   = ST_IDLE;
        w_finish = wb.wb_cyc_i;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register, request latch, wait counter and registered bus outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_hit   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_finish && r_hit;
      r_err   <= w_finish && !r_hit;
      if (w_accept) begin
        r_idx <= w_off[ADDR_WIDTH+1:2];
        r_dat <= wb.wb_dat_i;
        r_sel <= wb.wb_sel_i;
        r_we  <= wb.wb_we_i;
        r_hit <= w_hit;
        r_cnt <= 4'(WAIT_STATES);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_finish && r_hit && !r_we) r_dat_o <= r_mem[r_idx];
    end
  end

  // Byte-lane SRAM write on the completing edge of a write hit.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset so it maps onto RAM
    // macros; its power-up contents are undefined.
    if (w_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) r_mem[r_idx][8*b +: 8] <= r_dat[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_wb_sram_responder.sv
// Randomised scoreboard bench: two responders (0 and 3 wait states) driven by
// bus-master tasks; expected responses come from an array-based memory model.
module tb_wb_sram_responder;
  localparam int          AW    = 10;
  localparam int          DEPTH = 2 ** AW;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WS0   = 0;
  localparam int          WS1   = 3;

  typedef struct {
    int          d;
    int          resp_cyc;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel  [2];
  logic        we   [2];
  logic        cyc  [2];
  logic        stb  [2];
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        err  [2];

  int          cyc_n = 0;
  int          total = 0;
  int          bad   = 0;
  int          last_term [2];
  logic [31:0] hold_dat  [2];
  logic [31:0] ref_mem   [2][DEPTH];
  exp_t        sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  wb_sram_responder_if bus0 ();
  wb_sram_responder_if bus1 ();

  assign bus0.wb_adr_i = adr[0];  assign bus1.wb_adr_i = adr[1];
  assign bus0.wb_dat_i = wdat[0]; assign bus1.wb_dat_i = wdat[1];
  assign bus0.wb_sel_i = sel[0];  assign bus1.wb_sel_i = sel[1];
  assign bus0.wb_we_i  = we[0];   assign bus1.wb_we_i  = we[1];
  assign bus0.wb_cyc_i = cyc[0];  assign bus1.wb_cyc_i = cyc[1];
  assign bus0.wb_stb_i = stb[0];  assign bus1.wb_stb_i = stb[1];
  assign rdat[0] = bus0.wb_dat_o; assign rdat[1] = bus1.wb_dat_o;
  assign ack[0]  = bus0.wb_ack_o; assign ack[1]  = bus1.wb_ack_o;
  assign err[0]  = bus0.wb_err_o; assign err[1]  = bus1.wb_err_o;

  wb_sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(WS0)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .wb(bus0)
  );
  wb_sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(WS1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .wb(bus1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  // One complete bus transaction, issued at a negedge. The sampling edge is the
  // next edge, but never the edge that ends the previous termination cycle.
  task automatic txn(input int d, input bit w, input logic [31:0] a,
                     input logic [31:0] dt, input logic [3:0] s,
                     input bit hold, input bit scramble);
    int     samp;
    int     resp;
    int     idx;
    longint la;
    exp_t   e;
    samp = (cyc_n + 1 > last_term[d] + 2) ? cyc_n + 1 : last_term[d] + 2;
    resp = samp + 1 + ws_of(d);
    adr[d] = a; wdat[d] = dt; sel[d] = s; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
    la = longint'(a);
    e.d = d; e.resp_cyc = resp; e.rd = !w; e.data = '0;
    e.err = !(la >= longint'(BASE) && la < longint'(BASE) + longint'(DEPTH) * 4);
    if (!e.err) begin
      idx = int'((la - longint'(BASE)) / 4);
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[d][idx][8*b +: 8] = dt[8*b +: 8];
      end else begin
        e.data = ref_mem[d][idx];
      end
    end
    sb.push_back(e);
    while (cyc_n < resp) begin
      @(negedge clk);
      if (scramble && cyc_n >= samp && cyc_n < resp) begin
        wdat[d] = $urandom; sel[d] = 4'($urandom); we[d] = 1'($urandom);
      end
    end
    last_term[d] = resp;
    if (!hold) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
  endtask

  // Start a write to word 5, then kill it two cycles after it is sampled,
  // either by dropping cyc or by pulsing reset while cyc stays high.
  task automatic abort_write(input int d, input bit use_rst);
    int samp;
    samp = (cyc_n + 1 > last_term[d] + 2) ? cyc_n + 1 : last_term[d] + 2;
    adr[d] = BASE + 32'd20; wdat[d] = $urandom; sel[d] = 4'hF; we[d] = 1'b1;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    while (cyc_n < samp + 1) @(negedge clk);
    if (use_rst) begin
      rst[d] = 1'b1;
      repeat (2) @(negedge clk);
      cyc[d] = 1'b0; stb[d] = 1'b0;
      @(negedge clk);
      rst[d] = 1'b0;
    end else begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] pick_addr();
    int          r;
    logic [31:0] lo;
    r  = int'($urandom_range(0, 99));
    lo = 32'($urandom_range(0, 3));
    if (r < 55) return BASE + 32'(4 * $urandom_range(0, 15)) + lo;
    if (r < 70) return BASE + 32'(4 * $urandom_range(DEPTH - 4, DEPTH - 1)) + lo;
    if (r < 78) return BASE - 32'd4 + lo;
    if (r < 86) return BASE + 32'(4 * DEPTH) + lo;
    if (r < 93) return 32'($urandom_range(0, BASE - 1));
    return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 32'h00FF_FFFF));
  endfunction

  task automatic rand_run(input int d, input int n);
    bit held;
    bit hold;
    held = 1'b0;
    repeat (n) begin
      if (!held) repeat ($urandom_range(0, 2)) @(negedge clk);
      hold = 1'($urandom);
      txn(d, 1'($urandom), pick_addr(), $urandom, 4'($urandom), hold, 1'($urandom));
      held = hold;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every termination and tracks dat_o holding.
  always @(negedge clk) begin
    int   fi;
    exp_t e;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        hold_dat[d] = '0;
        check("ack_in_reset", 32'(ack[d]), 32'd0);
        check("err_in_reset", 32'(err[d]), 32'd0);
      end
      if (ack[d] || err[d]) begin
        check("ack_err_exclusive", 32'(ack[d] && err[d]), 32'd0);
        fi = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].d == d) begin fi = i; break; end
        end
        if (fi < 0) begin
          check("unexpected_termination", 32'(ack[d] || err[d]), 32'd0);
        end else begin
          e = sb[fi];
          sb.delete(fi);
          check("resp_cycle", 32'(cyc_n), 32'(e.resp_cyc));
          check("resp_is_err", 32'(err[d]), 32'(e.err));
          if (e.rd && !e.err) begin
            check("read_data", rdat[d], e.data);
            hold_dat[d] = e.data;
          end
        end
      end
      check("dat_o_hold", rdat[d], hold_dat[d]);
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; wdat[d] = '0; sel[d] = '0;
      last_term[d] = -10; hold_dat[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ack", 32'(ack[d]), 32'd0);
      check("reset_err", 32'(err[d]), 32'd0);
      check("reset_dat_o", rdat[d], 32'd0);
    end

    // Give every word the bench touches a defined value.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) txn(d, 1, BASE + 32'(4 * w), $urandom, 4'hF, 0, 0);
      for (int w = DEPTH - 4; w < DEPTH; w++) txn(d, 1, BASE + 32'(4 * w), $urandom, 4'hF, 0, 0);
    end

    // Basic write/read and byte lanes, zero wait states.
    txn(0, 1, BASE, 32'hDEAD_BEEF, 4'hF, 0, 0);
    txn(0, 0, BASE, 32'h0, 4'hF, 0, 0);
    txn(0, 1, BASE + 32'd4, 32'h1122_3344, 4'hF, 0, 0);
    txn(0, 1, BASE + 32'd4, 32'hAABB_CCDD, 4'b0101, 0, 0);
    txn(0, 0, BASE + 32'd4, 32'h0, 4'hF, 0, 0);
    txn(0, 1, BASE + 32'd4, 32'hFFFF_FFFF, 4'b0000, 0, 0);
    txn(0, 0, BASE + 32'd4, 32'h0, 4'hF, 0, 0);

    // Three wait states: latency is carried by the scoreboard entry.
    txn(1, 0, BASE, 32'h0, 4'hF, 0, 0);

    // Out-of-window reads on both sides, then the window is still intact.
    txn(0, 0, BASE - 32'd4, 32'h0, 4'hF, 0, 0);
    txn(0, 0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF, 0, 0);
    txn(0, 1, BASE - 32'd4, 32'h5555_AAAA, 4'hF, 0, 0);
    txn(0, 0, BASE, 32'h0, 4'hF, 0, 0);

    // Aborts by cyc drop and by reset leave word 5 untouched.
    txn(1, 0, BASE + 32'd20, 32'h0, 4'hF, 0, 0);
    abort_write(1, 0);
    txn(1, 0, BASE + 32'd20, 32'h0, 4'hF, 0, 0);
    abort_write(1, 1);
    txn(1, 0, BASE + 32'd20, 32'h0, 4'hF, 0, 0);

    // Back-to-back reads with stb held high.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) txn(d, 0, BASE + 32'(4 * i), 32'h0, 4'hF, i < 3, 0);

    fork
      rand_run(0, 150);
      rand_run(1, 150);
    join

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
